// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and limits for debounce_filter
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;
  localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous level into the clk domain
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain_q, chain_d;
  assign chain_d = {chain_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else chain_q <= chain_d;
  end
  assign q = chain_q[STAGES-1];
endmodule

// File: rtl/debounce_filter.sv
// debounce_filter: synchronizes and debounces a noisy level, with optional edge strobes
// Define DEBOUNCE_EDGE_EN to generate rise_pulse/fall_pulse; otherwise they are tied low.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int N  = SYNC_STAGES < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic sync_q;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic hi_done, lo_done;
  sync_chain #(.STAGES(N)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (sync_q)
  );
  assign hi_done = state_q == CHK_HIGH && sync_q && cnt_q == LAST;
  assign lo_done = state_q == CHK_LOW && !sync_q && cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      IDLE_LOW: if (sync_q) begin
        state_d = CHK_HIGH;
        cnt_d   = '0;
      end
      CHK_HIGH: begin
        state_d = !sync_q ? IDLE_LOW : hi_done ? IDLE_HIGH : CHK_HIGH;
        cnt_d   = (!sync_q || hi_done) ? '0 : cnt_q + 1'b1;
        level_d = hi_done ? 1'b1 : level_q;
      end
      IDLE_HIGH: if (!sync_q) begin
        state_d = CHK_LOW;
        cnt_d   = '0;
      end
      CHK_LOW: begin
        state_d = sync_q ? IDLE_HIGH : lo_done ? IDLE_LOW : CHK_LOW;
        cnt_d   = (sync_q || lo_done) ? '0 : cnt_q + 1'b1;
        level_d = lo_done ? 1'b0 : level_q;
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level_out = level_q;
`ifdef DEBOUNCE_EDGE_EN
  // Strobes register on the same edge as level_q, so they coincide with the new level.
  logic rise_q, fall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= hi_done;
      fall_q <= lo_done;
    end
  end
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif
endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth in flops (legal min 2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1000, consecutive stable synchronized samples needed to accept a new level (legal min 1).
REQ-003 SHALL have port clk, input, 1, single clock; all flops on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port raw_in, input, 1, asynchronous noisy level (switch/pin).
REQ-006 SHALL have port level_out, output, 1, debounced registered level; directly feeds the downstream d_ff d_in.
REQ-007 SHALL have port rise_pulse, output, 1, one-cycle strobe on accepted 0->1.
REQ-008 SHALL have port fall_pulse, output, 1, one-cycle strobe on accepted 1->0.

Function
REQ-009 SHALL pass raw_in through a SYNC_STAGES-flop chain; only the last stage (sync_q) is used by the filter.
REQ-010 SHALL implement FSM states IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW.
REQ-011 IDLE_LOW: sync_q=1 -> CHK_HIGH, cnt<=0; else stay.
REQ-012 CHK_HIGH: sync_q=0 -> IDLE_LOW, cnt<=0; sync_q=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, level_out<=1, cnt<=0; else cnt<=cnt+1.
REQ-013 IDLE_HIGH / CHK_LOW SHALL mirror REQ-011/012 with polarities inverted, ending in IDLE_LOW with level_out<=0.
REQ-014 Counter width SHALL be $clog2(STABLE_CYCLES+1); counter SHALL never wrap (cleared on every state exit).
REQ-015 Latency: raw_in step held stable -> level_out changes on the (SYNC_STAGES+STABLE_CYCLES+1)th posedge after the first sampling edge.
REQ-016 Any glitch shorter than STABLE_CYCLES synchronized cycles SHALL leave level_out unchanged and return to the originating IDLE state.
REQ-017 rise_pulse/fall_pulse SHALL be registered and high exactly on the cycle level_out first shows the new value; never both high.
REQ-018 All outputs SHALL be registered (no combinational path from raw_in).

Reset
REQ-019 rst_n low SHALL asynchronously clear sync chain, cnt, level_out, rise_pulse, fall_pulse to 0, FSM to IDLE_LOW.
REQ-020 Reset asserted mid-CHK_* SHALL discard the partial count; after release, a raw_in already high SHALL produce rise_pulse after the full REQ-015 latency.

Configuration
REQ-021 Macro DEBOUNCE_EDGE_EN defined: rise_pulse/fall_pulse generated per REQ-017.
REQ-022 Macro DEBOUNCE_EDGE_EN undefined: pulse logic SHALL be absent, ports retained and tied to 0; level_out behaviour identical.

Structure
REQ-023 Package debounce_pkg SHALL hold the FSM state enum typedef (2-bit logic) and the SYNC_STAGES minimum constant.
REQ-024 Synchronizer SHALL be sub-module sync_chain (parameter STAGES, ports clk, rst_n, d, q), async active-low reset to 0.

Verification (SYNC_STAGES=2, STABLE_CYCLES=4)
REQ-025 Reset, raw_in=0 -> level_out=0, both pulses 0, FSM IDLE_LOW for 20 cycles.
REQ-026 raw_in 0->1 held -> level_out=1 and rise_pulse=1 for one cycle on 7th posedge; level_out stays 1.
REQ-027 raw_in high for 3 cycles then low -> level_out stays 0, no pulses.
REQ-028 level_out=1, raw_in 1->0 held -> fall_pulse one cycle and level_out=0 on 7th posedge.
REQ-029 raw_in high, rst_n pulsed low during CHK_HIGH (cnt=2) -> outputs 0 immediately; after release, rise_pulse on 7th posedge.
REQ-030 Build without DEBOUNCE_EDGE_EN, repeat REQ-026/028 -> identical level_out timing, pulses constantly 0.
